// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data types, sync/CRC constants, TX FSM states and the
// header ECC function (also used by the receiver).
package csi2_pkg;

    localparam logic [5:0] DT_FS     = 6'h00;
    localparam logic [5:0] DT_FE     = 6'h01;
    localparam logic [5:0] DT_LS     = 6'h02;
    localparam logic [5:0] DT_LE     = 6'h03;
    localparam logic [5:0] DT_RGB565 = 6'h22;
    localparam logic [5:0] DT_RAW8   = 6'h2A;

    localparam logic [7:0]  SYNC_BYTE = 8'hB8;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'h8408;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_PAY,
        ST_CRC,
        ST_GAP
    } tx_state_t;

    function automatic logic is_long_dt(input logic [5:0] dt);
        return dt[5:4] != 2'b00;
    endfunction

    // d = {WC[15:0], DI}; returns the six Hamming parity bits of the header
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

endpackage

// File: rtl/csi2_crc16.sv
// CSI-2 payload CRC-16 (reflected 0x8408), NUM_LANES bytes per update, byte 0 first.
module csi2_crc16
    import csi2_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic                   en,
    input  logic [8*NUM_LANES-1:0] data,
    output logic [15:0]            crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int unsigned b = 0; b < NUM_LANES; b++) begin
            crc_d = crc_d ^ {8'h00, data[8*b +: 8]};
            for (int unsigned i = 0; i < 8; i++) begin
                crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY) : (crc_d >> 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/csi2_tx_packetizer.sv
// CSI-2 TX packetizer: sync, ECC header, payload, CRC footer and LP gap over NUM_LANES lanes.
// Define CSI2_TX_CRC_EN to compute the payload CRC; otherwise the footer is 0x0000.
module csi2_tx_packetizer
    import csi2_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned LP_GAP    = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [1:0]             pkt_vc,
    input  logic [5:0]             pkt_data_type,
    input  logic [15:0]            pkt_word_count,
    input  logic                   pay_valid,
    output logic                   pay_ready,
    input  logic [8*NUM_LANES-1:0] pay_data,
    output logic                   hs_active,
    output logic [8*NUM_LANES-1:0] lane_data,
    output logic [NUM_LANES-1:0]   lane_en,
    output logic                   err_wc,
    output logic                   busy
);

    localparam int unsigned LW      = 8*NUM_LANES;
    localparam int unsigned LOG2_NL = $clog2(NUM_LANES);
    localparam int unsigned GW      = $clog2(LP_GAP+1);

    localparam logic [1:0]           HDR_LAST = 2'(4/NUM_LANES - 1);
    localparam logic [1:0]           CRC_LAST = (NUM_LANES == 1) ? 2'd1 : 2'd0;
    localparam logic [GW-1:0]        GAP_LAST = GW'(LP_GAP - 1);
    localparam logic [15:0]          WC_MASK  = 16'(NUM_LANES - 1);
    localparam logic [NUM_LANES-1:0] FTR_EN   = (NUM_LANES == 4) ? NUM_LANES'(4'b0011)
                                                                 : {NUM_LANES{1'b1}};

    tx_state_t     state, state_d;
    logic [1:0]    phase, phase_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [15:0]   beat_cnt, beat_d;
    logic [1:0]    vc_q;
    logic [5:0]    dt_q;
    logic [15:0]   wc_q;
    logic          err_q, wc_err;
    logic [LW-1:0] hold_q;
    logic [15:0]   crc;

    logic [7:0]  di;
    logic [31:0] hdr_word;
    logic [31:0] ftr_word;
    logic [15:0] beats_total;

    assign di          = {vc_q, dt_q};
    assign hdr_word    = {2'b00, ecc6({wc_q, di}), wc_q[15:8], wc_q[7:0], di};
    assign ftr_word    = {16'h0000, crc};
    assign beats_total = wc_q >> LOG2_NL;
    assign err_wc      = err_q;

    always_comb begin
        state_d   = state;
        phase_d   = phase;
        gap_d     = gap_cnt;
        beat_d    = beat_cnt;
        wc_err    = 1'b0;
        pkt_ready = 1'b0;
        pay_ready = 1'b0;
        hs_active = 1'b0;
        lane_data = '0;
        lane_en   = '0;
        busy      = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    if (is_long_dt(pkt_data_type) && ((pkt_word_count & WC_MASK) != '0)) begin
                        wc_err = 1'b1;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
            end
            ST_SYNC: begin
                hs_active = 1'b1;
                lane_en   = '1;
                lane_data = {NUM_LANES{SYNC_BYTE}};
                phase_d   = '0;
                state_d   = ST_HDR;
            end
            ST_HDR: begin
                hs_active = 1'b1;
                lane_en   = '1;
                lane_data = LW'(hdr_word >> (LW * 32'(phase)));
                if (phase == HDR_LAST) begin
                    phase_d = '0;
                    beat_d  = '0;
                    gap_d   = '0;
                    if (!is_long_dt(dt_q)) begin
                        state_d = ST_GAP;
                    end else if (wc_q == '0) begin
                        state_d = ST_CRC;
                    end else begin
                        state_d = ST_PAY;
                    end
                end else begin
                    phase_d = phase + 2'd1;
                end
            end
            ST_PAY: begin
                hs_active = 1'b1;
                pay_ready = 1'b1;
                if (pay_valid) begin
                    lane_en   = '1;
                    lane_data = pay_data;
                    beat_d    = beat_cnt + 16'd1;
                    if (beat_d == beats_total) begin
                        state_d = ST_CRC;
                    end
                end else begin
                    // stall: keep the previous lane bytes on the wire
                    lane_data = hold_q;
                end
            end
            ST_CRC: begin
                hs_active = 1'b1;
                lane_en   = FTR_EN;
                lane_data = LW'(ftr_word >> (LW * 32'(phase)));
                if (phase == CRC_LAST) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    phase_d = phase + 2'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!resetn) begin
            wc_err    = 1'b0;
            pkt_ready = 1'b0;
            pay_ready = 1'b0;
            hs_active = 1'b0;
            lane_data = '0;
            lane_en   = '0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            phase    <= '0;
            gap_cnt  <= '0;
            beat_cnt <= '0;
            vc_q     <= '0;
            dt_q     <= '0;
            wc_q     <= '0;
            err_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            state    <= state_d;
            phase    <= phase_d;
            gap_cnt  <= gap_d;
            beat_cnt <= beat_d;
            err_q    <= wc_err;
            hold_q   <= lane_data;
            if (state == ST_IDLE && pkt_valid) begin
                vc_q <= pkt_vc;
                dt_q <= pkt_data_type;
                wc_q <= pkt_word_count;
            end
        end
    end

`ifdef CSI2_TX_CRC_EN
    logic crc_clear;
    logic crc_en;

    assign crc_clear = (state == ST_GAP) && (gap_cnt == GAP_LAST);
    assign crc_en    = (state == ST_PAY) && pay_valid && resetn;

    csi2_crc16 #(.NUM_LANES(NUM_LANES)) u_crc (
        .clk    (clk),
        .resetn (resetn),
        .clear  (crc_clear),
        .en     (crc_en),
        .data   (pay_data),
        .crc    (crc)
    );
`else
    assign crc = '0;
`endif

endmodule

// File: tb/tb_csi2_tx_packetizer.sv
// Self-checking bench: 2-lane and 4-lane packetizers against a byte-stream reference model.
module tb_csi2_tx_packetizer;

    logic        clk;
    logic        resetn;

    logic        pkt_valid_a, pkt_ready_a, pay_valid_a, pay_ready_a, hs_a, err_a, busy_a;
    logic [1:0]  pkt_vc_a;
    logic [5:0]  pkt_dt_a;
    logic [15:0] pkt_wc_a;
    logic [15:0] pay_data_a, lane_data_a;
    logic [1:0]  lane_en_a;

    logic        pkt_valid_b, pkt_ready_b, pay_valid_b, pay_ready_b, hs_b, err_b, busy_b;
    logic [1:0]  pkt_vc_b;
    logic [5:0]  pkt_dt_b;
    logic [15:0] pkt_wc_b;
    logic [31:0] pay_data_b, lane_data_b;
    logic [3:0]  lane_en_b;

    int vectors;
    int miscompares;

    logic        o_pr, o_yr, o_hs, o_err, o_busy;
    logic [31:0] o_data;
    logic [3:0]  o_en;

    csi2_tx_packetizer #(.NUM_LANES(2), .LP_GAP(8)) u_dut2 (
        .clk(clk), .resetn(resetn),
        .pkt_valid(pkt_valid_a), .pkt_ready(pkt_ready_a), .pkt_vc(pkt_vc_a),
        .pkt_data_type(pkt_dt_a), .pkt_word_count(pkt_wc_a),
        .pay_valid(pay_valid_a), .pay_ready(pay_ready_a), .pay_data(pay_data_a),
        .hs_active(hs_a), .lane_data(lane_data_a), .lane_en(lane_en_a),
        .err_wc(err_a), .busy(busy_a)
    );

    csi2_tx_packetizer #(.NUM_LANES(4), .LP_GAP(3)) u_dut4 (
        .clk(clk), .resetn(resetn),
        .pkt_valid(pkt_valid_b), .pkt_ready(pkt_ready_b), .pkt_vc(pkt_vc_b),
        .pkt_data_type(pkt_dt_b), .pkt_word_count(pkt_wc_b),
        .pay_valid(pay_valid_b), .pay_ready(pay_ready_b), .pay_data(pay_data_b),
        .hs_active(hs_b), .lane_data(lane_data_b), .lane_en(lane_en_b),
        .err_wc(err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int sel, input logic pv, input logic [1:0] vc, input logic [5:0] dt,
                         input logic [15:0] wc, input logic yv, input logic [31:0] yd);
        if (sel == 0) begin
            pkt_valid_a = pv; pkt_vc_a = vc; pkt_dt_a = dt; pkt_wc_a = wc;
            pay_valid_a = yv; pay_data_a = yd[15:0];
        end else begin
            pkt_valid_b = pv; pkt_vc_b = vc; pkt_dt_b = dt; pkt_wc_b = wc;
            pay_valid_b = yv; pay_data_b = yd;
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            o_pr = pkt_ready_a; o_yr = pay_ready_a; o_hs = hs_a; o_err = err_a; o_busy = busy_a;
            o_data = {16'h0000, lane_data_a}; o_en = {2'b00, lane_en_a};
        end else begin
            o_pr = pkt_ready_b; o_yr = pay_ready_b; o_hs = hs_b; o_err = err_b; o_busy = busy_b;
            o_data = lane_data_b; o_en = lane_en_b;
        end
    endtask

    // Header ECC as XOR of per-bit Hamming syndrome columns
    function automatic logic [5:0] model_ecc(input logic [23:0] d);
        logic [5:0] col [24];
        logic [5:0] e;
        col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
                6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
        e = 6'h00;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= col[i];
        return e;
    endfunction

    // Bit-serial LSB-first CRC-16 over the whole payload
    function automatic logic [15:0] model_crc(input logic [7:0] bytes [$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (bytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ bytes[i][b];
                c  = c >> 1;
                if (fb) c ^= 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic send_pkt(input int sel, input logic [1:0] vc, input logic [5:0] dt,
                            input logic [15:0] wc, input int stall_pct);
        int          nl, gap_len, beats, bi, hs_cyc, gap_cyc, budget;
        bit          is_long, seen_hs, done, gap_lanes;
        logic [7:0]  pay [$];
        logic [7:0]  expq [$];
        logic [7:0]  got [$];
        logic [15:0] crc;
        logic [7:0]  di;
        logic [3:0]  last_en;
        logic [31:0] beat, hold;
        logic        pv;

        nl      = (sel != 0) ? 4 : 2;
        gap_len = (sel != 0) ? 3 : 8;
        is_long = (dt >= 6'h10);
        di      = {vc, dt};
        for (int k = 0; k < nl; k++) expq.push_back(8'hB8);
        expq.push_back(di);
        expq.push_back(wc[7:0]);
        expq.push_back(wc[15:8]);
        expq.push_back({2'b00, model_ecc({wc, di})});
        if (is_long) begin
            for (int k = 0; k < int'(wc); k++) begin
                pay.push_back(8'($urandom));
                expq.push_back(pay[k]);
            end
`ifdef CSI2_TX_CRC_EN
            crc = model_crc(pay);
`else
            crc = 16'h0000;
`endif
            expq.push_back(crc[7:0]);
            expq.push_back(crc[15:8]);
        end
        beats = is_long ? int'(wc) / nl : 0;

        @(posedge clk); #1;
        drive(sel, 1'b1, vc, dt, wc, 1'b0, 32'h0);
        #1; sample(sel);
        check("req_ready", {31'b0, o_pr}, 32'd1);

        bi = 0; hs_cyc = 0; gap_cyc = 0; budget = 0;
        seen_hs = 0; done = 0; gap_lanes = 0; last_en = 4'h0;
        while (!done && budget < 3000) begin
            budget++;
            @(posedge clk); #1;
            pv   = !(stall_pct > 0 && $urandom_range(99) < stall_pct);
            beat = 32'h0;
            for (int k = 0; k < nl; k++)
                if (bi*nl + k < pay.size()) beat[8*k +: 8] = pay[bi*nl + k];
            drive(sel, 1'b0, vc, dt, wc, pv, beat);
            #1; sample(sel);
            if (o_hs) begin
                seen_hs = 1;
                if (o_yr && !pv) begin
                    hold = 32'h0;
                    for (int k = 0; k < nl; k++) hold[8*k +: 8] = expq[got.size() - nl + k];
                    check("stall_en", {28'b0, o_en}, 32'd0);
                    check("stall_hold", o_data, hold);
                end else begin
                    hs_cyc++;
                    last_en = o_en;
                    for (int k = 0; k < nl; k++) if (o_en[k]) got.push_back(o_data[8*k +: 8]);
                    if (sel != 0 && o_en == 4'b0011) check("ftr_upper_lanes", {16'h0, o_data[31:16]}, 32'd0);
                end
                if (o_yr && pv) bi++;
            end else if (seen_hs) begin
                if (o_busy) begin
                    gap_cyc++;
                    if (o_en != 4'h0) gap_lanes = 1;
                end else begin
                    done = 1;
                end
            end
        end

        check("timeout", {31'b0, done}, 32'd1);
        check("hs_cycles", hs_cyc, 32'(1 + 4/nl + (is_long ? beats + 1 : 0)));
        check("gap_len", gap_cyc, gap_len);
        check("gap_lanes_off", {31'b0, gap_lanes}, 32'd0);
        check("last_en", {28'b0, last_en},
              (sel != 0) ? (is_long ? 32'h3 : 32'hF) : 32'h3);
        check("ready_back", {31'b0, o_pr}, 32'd1);
        check("stream_len", got.size(), expq.size());
        for (int k = 0; k < expq.size() && k < got.size(); k++)
            check($sformatf("byte%0d", k), {24'h0, got[k]}, {24'h0, expq[k]});
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        resetn = 1'b0;
        drive(0, 1'b0, 2'd0, 6'h00, 16'h0, 1'b0, 32'h0);
        drive(1, 1'b0, 2'd0, 6'h00, 16'h0, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #2;
        for (int s = 0; s < 2; s++) begin
            sample(s);
            check("rst_pkt_ready", {31'b0, o_pr}, 32'd0);
            check("rst_pay_ready", {31'b0, o_yr}, 32'd0);
            check("rst_hs", {31'b0, o_hs}, 32'd0);
            check("rst_lane_data", o_data, 32'd0);
            check("rst_lane_en", {28'b0, o_en}, 32'd0);
            check("rst_err", {31'b0, o_err}, 32'd0);
            check("rst_busy", {31'b0, o_busy}, 32'd0);
        end
        @(posedge clk); #1 resetn = 1'b1;
        #1; sample(0);
        check("idle_ready", {31'b0, o_pr}, 32'd1);

        send_pkt(0, 2'd0, 6'h00, 16'h0000, 0);
        send_pkt(0, 2'd1, 6'h2A, 16'h0000, 0);
        send_pkt(0, 2'd2, 6'h22, 16'd1280, 0);

        // odd long word count on 2 lanes is rejected
        @(posedge clk); #1;
        drive(0, 1'b1, 2'd0, 6'h2A, 16'd3, 1'b0, 32'h0);
        #1; sample(0);
        check("err_req_ready", {31'b0, o_pr}, 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'd0, 6'h2A, 16'd3, 1'b0, 32'h0);
        #1; sample(0);
        check("err_pulse", {31'b0, o_err}, 32'd1);
        check("err_hs", {31'b0, o_hs}, 32'd0);
        check("err_ready", {31'b0, o_pr}, 32'd1);
        @(posedge clk); #2; sample(0);
        check("err_single", {31'b0, o_err}, 32'd0);
        check("err_idle", {31'b0, o_busy}, 32'd0);

        send_pkt(0, 2'd3, 6'h2A, 16'd64, 30);

        // abort a packet mid-payload with reset
        @(posedge clk); #1;
        drive(0, 1'b1, 2'd1, 6'h2A, 16'd40, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 2'd1, 6'h2A, 16'd40, 1'b1, $urandom);
        end
        #1; sample(0);
        check("pre_abort_pay", {31'b0, o_yr}, 32'd1);
        @(posedge clk); #1 resetn = 1'b0;
        #1; sample(0);
        check("abort_hs", {31'b0, o_hs}, 32'd0);
        check("abort_en", {28'b0, o_en}, 32'd0);
        check("abort_pay_ready", {31'b0, o_yr}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        drive(0, 1'b0, 2'd0, 6'h00, 16'h0, 1'b0, 32'h0);
        #1; sample(0);
        check("post_abort_ready", {31'b0, o_pr}, 32'd1);
        check("post_abort_busy", {31'b0, o_busy}, 32'd0);
        check("post_abort_hs", {31'b0, o_hs}, 32'd0);
        send_pkt(0, 2'd0, 6'h2A, 16'd32, 10);

        send_pkt(1, 2'd1, 6'h2A, 16'd8, 0);
        send_pkt(1, 2'd2, 6'h02, 16'h1234, 0);

        for (int i = 0; i < 6; i++) begin
            int          s;
            logic [5:0]  dt;
            logic [15:0] wc;
            s = i % 2;
            if ($urandom_range(1) != 0) begin
                dt = 6'(6'h10 + $urandom_range(47));
                wc = 16'(((s != 0) ? 4 : 2) * $urandom_range(24));
            end else begin
                dt = 6'($urandom_range(15));
                wc = 16'($urandom);
            end
            send_pkt(s, 2'($urandom), dt, wc, 20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
